rr_resource_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 12 +
 rtl/rr_resource_arbiter_if.sv | 26 ++
 rtl/prio_enc_n.sv | 21 ++
 rtl/rr_resource_arbiter.sv | 105 ++++++++++
 tb/tb_rr_resource_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin resource arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_e;

  localparam int ARB_N        = 4;
  localparam int ARB_MAX_HOLD = 16;

endpackage

// File: rtl/rr_resource_arbiter_if.sv
// Request/grant bundle between the requesting agents and the arbiter.
interface rr_resource_arbiter_if
  import arb_pkg::*;
#(
  parameter int N   = ARB_N,
  parameter int IDW = $clog2(N)
);

  logic [N-1:0]   req;
  logic           rr_en;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_vld;
  logic           timeout;

  modport master (
    output req, rr_en,
    input  gnt, gnt_id, gnt_vld, timeout
  );

  modport slave (
    input  req, rr_en,
    output gnt, gnt_id, gnt_vld, timeout
  );

endinterface

// File: rtl/prio_enc_n.sv
// Combinational priority encoder: the highest set index wins.
// The index is always driven, and it reads 0 when no bit is set.
module prio_enc_n #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   vec,
  output logic [IDW-1:0] idx,
  output logic           valid
);

  // Later iterations overwrite earlier ones, so the highest set bit sticks.
  always_comb begin
    idx   = '0;
    valid = |vec;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) idx = IDW'(i);
    end
  end

endmodule

// File: rtl/rr_resource_arbiter.sv
// Single-owner arbiter with optional round-robin priority and a hold timeout.
// The selection core rotates the eligible vector so that a fixed encoder serves both modes.
module rr_resource_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int IDW      = $clog2(N),
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input logic                  clk,
  input logic                  rst,
  rr_resource_arbiter_if.slave bus
);

  localparam int              HCW        = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0]  HOLD_LIMIT = HCW'(MAX_HOLD);
  localparam logic [IDW:0]    N_W        = (IDW + 1)'(N);
  localparam logic [N-1:0]    ONE_HOT0   = N'(1);

  arb_state_e     state;
  logic [IDW-1:0] last_owner;
  logic [HCW-1:0] hold_cnt;
  logic [N-1:0]   mask;

  logic [N-1:0]   eligible;
  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;
  logic [IDW-1:0] shift;
  logic [IDW-1:0] enc_idx;
  logic           enc_vld;
  logic [IDW:0]   wsum;
  logic [IDW-1:0] winner;
  logic           owner_req;

  assign eligible  = bus.req & ~mask;
  assign shift     = bus.rr_en ? last_owner : '0;
  assign doubled   = {eligible, eligible};
  // Bit N-1 of the rotated vector is requester last_owner-1, so it is searched first.
  assign rotated   = doubled[shift +: N];
  assign owner_req = bus.req[bus.gnt_id];

  prio_enc_n #(
    .N   (N),
    .IDW (IDW)
  ) u_enc (
    .vec   (rotated),
    .idx   (enc_idx),
    .valid (enc_vld)
  );

  // Undo the rotation: winner = (enc_idx + shift) mod N.
  always_comb begin
    wsum = {1'b0, enc_idx} + {1'b0, shift};
    if (wsum >= N_W) wsum = wsum - N_W;
    winner = wsum[IDW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bus.gnt     <= '0;
      bus.gnt_id  <= '0;
      bus.gnt_vld <= 1'b0;
      bus.timeout <= 1'b0;
      last_owner  <= '0;
      hold_cnt    <= '0;
      mask        <= '0;
    end else begin
      bus.timeout <= 1'b0;
      mask        <= mask & bus.req;
      case (state)
        IDLE: begin
          if (enc_vld) begin
            bus.gnt     <= ONE_HOT0 << winner;
            bus.gnt_id  <= winner;
            bus.gnt_vld <= 1'b1;
            last_owner  <= winner;
            hold_cnt    <= HCW'(1);
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (!owner_req) begin
            bus.gnt     <= '0;
            bus.gnt_id  <= '0;
            bus.gnt_vld <= 1'b0;
            state       <= IDLE;
          end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LIMIT) begin
            // The revoked owner stays masked until it drops its request once.
            bus.gnt     <= '0;
            bus.gnt_id  <= '0;
            bus.gnt_vld <= 1'b0;
            bus.timeout <= 1'b1;
            mask        <= (mask & bus.req) | (ONE_HOT0 << bus.gnt_id);
            state       <= IDLE;
          end else if (MAX_HOLD != 0 && hold_cnt != HOLD_LIMIT) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Self-checking bench for rr_resource_arbiter: directed scenarios plus a randomized run
// compared cycle by cycle against a rule-level ownership model.
module tb_rr_resource_arbiter;

  localparam int N    = 4;
  localparam int MAXH = 16;

  logic clk = 1'b0;
  logic rst;
  int   total;
  int   bad;

  // Reference model state
  int   m_owner;
  int   m_hold;
  int   m_last;
  bit   m_mask [N];
  bit   m_to;

  rr_resource_arbiter_if #(.N(N), .IDW(2)) bus ();

  rr_resource_arbiter #(
    .N        (N),
    .IDW      (2),
    .MAX_HOLD (MAXH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic pulse_reset();
    bus.req   = '0;
    bus.rr_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic model_init();
    m_owner = -1;
    m_hold  = 0;
    m_last  = 0;
    m_to    = 0;
    for (int i = 0; i < N; i++) m_mask[i] = 0;
  endtask

  // One clock edge of the arbiter's rules, applied to the inputs sampled at that edge.
  task automatic model_step(input logic [N-1:0] r, input logic re);
    int win;
    win = -1;
    m_to = 0;
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = re ? (m_last - k + N) % N : N - k;
        if (win < 0 && r[c] && !m_mask[c]) win = c;
      end
      if (win >= 0) begin
        m_owner = win;
        m_hold  = 1;
        m_last  = win;
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
    end else if (MAXH != 0 && m_hold == MAXH) begin
      m_mask[m_owner] = 1;
      m_owner = -1;
      m_to = 1;
    end else if (m_hold < MAXH) begin
      m_hold++;
    end
    for (int i = 0; i < N; i++) if (!r[i]) m_mask[i] = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.rr_en = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.gnt !== 4'b0000 || bus.gnt_vld !== 1'b0 || bus.gnt_id !== 2'd0 || bus.timeout !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_values got gnt=%b id=%0d vld=%b to=%b want 0000/0/0/0",
               bus.gnt, bus.gnt_id, bus.gnt_vld, bus.timeout);
    end
    rst = 1'b0;
    bus.req = 4'b1000;
    @(negedge clk);
    total++;
    if (bus.gnt !== 4'b1000 || bus.gnt_id !== 2'd3) begin
      bad++;
      $display("[TB] FAIL reset_first_grant got gnt=%b id=%0d want 1000/3", bus.gnt, bus.gnt_id);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus.gnt !== 4'b0000 || bus.gnt_id !== 2'd0 || bus.gnt_vld !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_async got gnt=%b id=%0d vld=%b want 0000/0/0",
               bus.gnt, bus.gnt_id, bus.gnt_vld);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.gnt !== 4'b1000 || bus.gnt_vld !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_regrant got gnt=%b vld=%b want 1000/1", bus.gnt, bus.gnt_vld);
    end
    bus.req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fixed_priority();
    bus.rr_en = 1'b0;
    bus.req = 4'b0110;
    @(negedge clk);
    total++;
    if (bus.gnt !== 4'b0100 || bus.gnt_id !== 2'd2) begin
      bad++;
      $display("[TB] FAIL fixed_first got gnt=%b id=%0d want 0100/2", bus.gnt, bus.gnt_id);
    end
    bus.req = 4'b0010;
    @(negedge clk);
    total++;
    if (bus.gnt_vld !== 1'b0 || bus.gnt !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL fixed_idle_gap got gnt=%b vld=%b want 0000/0", bus.gnt, bus.gnt_vld);
    end
    @(negedge clk);
    total++;
    if (bus.gnt !== 4'b0010 || bus.gnt_id !== 2'd1) begin
      bad++;
      $display("[TB] FAIL fixed_second got gnt=%b id=%0d want 0010/1", bus.gnt, bus.gnt_id);
    end
    bus.req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_round_robin();
    int order [5] = '{3, 2, 1, 0, 3};
    pulse_reset();
    bus.rr_en = 1'b1;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (bus.gnt !== 4'(1 << order[k]) || bus.gnt_id !== 2'(order[k])) begin
        bad++;
        $display("[TB] FAIL rr_grant%0d got gnt=%b id=%0d want id=%0d", k, bus.gnt, bus.gnt_id, order[k]);
      end
      bus.req = 4'b1111 & ~4'(1 << order[k]);
      @(negedge clk);
      total++;
      if (bus.gnt_vld !== 1'b0) begin
        bad++;
        $display("[TB] FAIL rr_release%0d got vld=%b want 0", k, bus.gnt_vld);
      end
      bus.req = 4'b1111;
    end
    bus.req = '0;
    bus.rr_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    int held;
    held = 0;
    bus.rr_en = 1'b0;
    bus.req = 4'b0001;
    for (int c = 0; c < MAXH; c++) begin
      @(negedge clk);
      if (bus.gnt === 4'b0001 && bus.gnt_vld === 1'b1) held++;
    end
    total++;
    if (held != MAXH) begin
      bad++;
      $display("[TB] FAIL timeout_hold_len got %0d want %0d", held, MAXH);
    end
    @(negedge clk);
    total++;
    if (bus.gnt_vld !== 1'b0 || bus.timeout !== 1'b1) begin
      bad++;
      $display("[TB] FAIL timeout_pulse got vld=%b to=%b want 0/1", bus.gnt_vld, bus.timeout);
    end
    repeat (3) begin
      @(negedge clk);
      total++;
      if (bus.gnt_vld !== 1'b0 || bus.timeout !== 1'b0) begin
        bad++;
        $display("[TB] FAIL timeout_masked got vld=%b to=%b want 0/0", bus.gnt_vld, bus.timeout);
      end
    end
    bus.req = 4'b0000;
    @(negedge clk);
    bus.req = 4'b0001;
    @(negedge clk);
    total++;
    if (bus.gnt !== 4'b0001) begin
      bad++;
      $display("[TB] FAIL timeout_regrant got gnt=%b want 0001", bus.gnt);
    end
    bus.req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_no_preempt();
    bus.rr_en = 1'b0;
    bus.req = 4'b0001;
    @(negedge clk);
    bus.req = 4'b1001;
    repeat (4) begin
      @(negedge clk);
      total++;
      if (bus.gnt !== 4'b0001) begin
        bad++;
        $display("[TB] FAIL no_preempt_hold got gnt=%b want 0001", bus.gnt);
      end
    end
    bus.req = 4'b1000;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.gnt !== 4'b1000) begin
      bad++;
      $display("[TB] FAIL no_preempt_next got gnt=%b want 1000", bus.gnt);
    end
    bus.req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic [N-1:0] exp_gnt;
    logic [1:0]   exp_id;
    int           run_len;
    run_len = 0;
    pulse_reset();
    model_init();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      r = bus.req;
      for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
      bus.req = r;
      if ($urandom_range(0, 7) == 0) bus.rr_en = ~bus.rr_en;
      model_step(r, bus.rr_en);
      @(negedge clk);
      exp_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      exp_id  = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
      total++;
      if (bus.gnt !== exp_gnt || bus.gnt_id !== exp_id ||
          bus.gnt_vld !== (m_owner >= 0) || bus.timeout !== m_to) begin
        bad++;
        $display("[TB] FAIL random_c%0d got gnt=%b id=%0d vld=%b to=%b want gnt=%b id=%0d vld=%b to=%b",
                 cyc, bus.gnt, bus.gnt_id, bus.gnt_vld, bus.timeout,
                 exp_gnt, exp_id, (m_owner >= 0), m_to);
      end
      run_len = (bus.gnt_vld === 1'b1) ? run_len + 1 : 0;
      total++;
      if (run_len > MAXH) begin
        bad++;
        $display("[TB] FAIL random_hold_c%0d got run=%0d want <=%0d", cyc, run_len, MAXH);
      end
    end
    bus.req = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_timeout();
    test_no_preempt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
